// File: rtl/floparray_arb_pkg.sv
// Shared types and helpers for the flop-array arbiter and its round-robin core.
package floparray_arb_pkg;

  // Controller phases: INIT after reset, CLEAR while zeroing, RUN while serving.
  typedef enum logic [1:0] {
    INIT  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2
  } arb_state_t;

  // Index width for a count of n items; never narrower than one bit.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first asserted request at or after ptr
// (ascending, wrapping) wins. The pointer register lives in the caller.
module rr_arbiter
  import floparray_arb_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  localparam int PW      = addr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant
);

  // Walk the requests once starting at ptr and grant the first one found.
  always_comb begin
    int   idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    grant = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/floparray_arbiter.sv
// Shares one flop buffer (1-cycle sync read, one op per cycle) between NUM_REQ
// requesters with round-robin arbitration, and zeroes the whole buffer after
// reset or on clear_req before handing it back to the requesters.
module floparray_arbiter
  import floparray_arb_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  parameter int  DEPTH   = 32,
  parameter int  WIDTH   = 256,
  localparam int AW      = addr_width(DEPTH),
  localparam int PW      = addr_width(NUM_REQ)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_write,
  input  logic [NUM_REQ*AW-1:0]    req_addr,
  input  logic [NUM_REQ*WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_data,
  input  logic                     clear_req,
  output logic                     busy,
  output logic                     clear_done,
  output logic [AW-1:0]            buf_raddr,
  output logic                     buf_ren,
  output logic [AW-1:0]            buf_waddr,
  output logic                     buf_wen,
  output logic [WIDTH-1:0]         buf_wdata,
  input  logic [WIDTH-1:0]         buf_rdata
);

  arb_state_t           state;
  logic [AW-1:0]        clr_cnt;
  logic [PW-1:0]        rr_ptr;
  logic [NUM_REQ-1:0]   arb_req;
  logic [NUM_REQ-1:0]   grant;
  logic                 any_grant;
  logic [PW-1:0]        win_idx;
  logic                 win_write;
  logic [AW-1:0]        win_addr;
  logic [WIDTH-1:0]     win_wdata;
  logic                 clr_last;
  logic [PW-1:0]        ptr_next;

  // Requesters only compete while the buffer is in service.
  assign arb_req = req_valid & {NUM_REQ{state == RUN}};

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req   (arb_req),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  // Encode the one-hot grant so the winner's fields can be muxed out.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) win_idx = PW'(i);
    end
  end

  assign any_grant = |grant;
  assign win_write = req_write[win_idx];
  assign win_addr  = req_addr[win_idx*AW +: AW];
  assign win_wdata = req_wdata[win_idx*WIDTH +: WIDTH];
  assign clr_last  = (clr_cnt == AW'(DEPTH - 1));
  assign ptr_next  = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + PW'(1);

  // Drive the buffer port: sweep writes in CLEAR, the winner's op in RUN,
  // nothing in INIT. Read and write enables are mutually exclusive by design.
  always_comb begin
    req_ready = '0;
    buf_ren   = 1'b0;
    buf_wen   = 1'b0;
    buf_raddr = '0;
    buf_waddr = '0;
    buf_wdata = '0;
    case (state)
      CLEAR: begin
        buf_wen   = 1'b1;
        buf_waddr = clr_cnt;
      end
      RUN: begin
        req_ready = grant;
        if (any_grant) begin
          if (win_write) begin
            buf_wen   = 1'b1;
            buf_waddr = win_addr;
            buf_wdata = win_wdata;
          end else begin
            buf_ren   = 1'b1;
            buf_raddr = win_addr;
          end
        end
      end
      default: ;
    endcase
  end

  assign busy       = (state != RUN);
  assign clear_done = (state == CLEAR) && clr_last;
  // Read data is only meaningful (and only non-zero) the cycle after a read grant.
  assign rsp_data   = (|rsp_valid) ? buf_rdata : '0;

  // Sequence INIT -> CLEAR -> RUN, advance the sweep and the round-robin
  // pointer, and register which requester the next read data belongs to.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= INIT;
      clr_cnt   <= '0;
      rr_ptr    <= '0;
      rsp_valid <= '0;
    end else begin
      rsp_valid <= '0;
      case (state)
        INIT: begin
          state   <= CLEAR;
          clr_cnt <= '0;
        end
        CLEAR: begin
          if (clr_last) begin
            state   <= RUN;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + AW'(1);
          end
        end
        RUN: begin
          if (any_grant) begin
            rr_ptr <= ptr_next;
            if (!win_write) rsp_valid <= grant;
          end
          if (clear_req) state <= CLEAR;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_floparray_arbiter.sv
// Directed bench for floparray_arbiter with a behavioural flop buffer attached
// to the buf_* port and a scoreboard memory for the mixed-traffic section.
module tb_floparray_arbiter;

  localparam int NR = 4;
  localparam int DP = 32;
  localparam int WD = 256;
  localparam int AW = 5;
  localparam logic [WD-1:0] PAT_A5 = {32{8'hA5}};
  localparam logic [WD-1:0] GARBAGE = {8{32'hDEADBEEF}};

  logic              clock;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_write;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*WD-1:0]  req_wdata;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     rsp_valid;
  logic [WD-1:0]     rsp_data;
  logic              clear_req;
  logic              busy;
  logic              clear_done;
  logic [AW-1:0]     buf_raddr;
  logic              buf_ren;
  logic [AW-1:0]     buf_waddr;
  logic              buf_wen;
  logic [WD-1:0]     buf_wdata;
  logic [WD-1:0]     buf_rdata;

  int n_vec = 0;
  int n_err = 0;

  logic [WD-1:0] mem [DP];
  logic [WD-1:0] sb  [DP];
  logic [NR-1:0] pend_vld;
  logic [WD-1:0] pend_data;
  logic [WD-1:0] rnd_d;
  logic [NR-1:0] exp_rdy;
  int            mptr;
  int            g;
  int            idx;
  logic          found;
  logic [AW-1:0] a_tmp;
  int            nwait;

  floparray_arbiter #(.NUM_REQ(NR), .DEPTH(DP), .WIDTH(WD)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .clear_req  (clear_req),
    .busy       (busy),
    .clear_done (clear_done),
    .buf_raddr  (buf_raddr),
    .buf_ren    (buf_ren),
    .buf_waddr  (buf_waddr),
    .buf_wen    (buf_wen),
    .buf_wdata  (buf_wdata),
    .buf_rdata  (buf_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural flop buffer: sync read, write dropped when read in same cycle.
  // Reset fills it with garbage so the sweep has something to erase.
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DP; i++) mem[i] <= GARBAGE;
    end else begin
      if (buf_ren) buf_rdata <= mem[buf_raddr];
      if (buf_wen && !buf_ren) mem[buf_waddr] <= buf_wdata;
    end
  end

  task automatic check_eq(input string tag, input logic [WD-1:0] got, input logic [WD-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Read and write enables must never coincide.
  always @(negedge clock) check_eq("ren_wen_excl", WD'(buf_ren & buf_wen), '0);

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    clear_req = 1'b0;
  endtask

  task automatic set_req(input int i, input logic v, input logic w,
                         input logic [AW-1:0] a, input logic [WD-1:0] d);
    req_valid[i]         = v;
    req_write[i]         = w;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*WD +: WD] = d;
  endtask

  function automatic logic [WD-1:0] ph3_data(input int i);
    return (i % 2 == 0) ? PAT_A5 : '0;
  endfunction

  initial begin
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    // Reset values
    check_eq("rst_ready", req_ready, '0);
    check_eq("rst_rsp_valid", rsp_valid, '0);
    check_eq("rst_busy", busy, 1);
    check_eq("rst_clear_done", clear_done, 0);
    check_eq("rst_wen", buf_wen, 0);
    check_eq("rst_ren", buf_ren, 0);
    check_eq("rst_waddr", buf_waddr, 0);
    check_eq("rst_wdata", buf_wdata, 0);

    reset = 1'b0;
    #1;
    check_eq("init_busy", busy, 1);
    check_eq("init_wen", buf_wen, 0);
    cyc();
    // Power-up sweep over every address
    for (int k = 0; k < DP; k++) begin
      check_eq("sweep_busy", busy, 1);
      check_eq("sweep_wen", buf_wen, 1);
      check_eq("sweep_ren", buf_ren, 0);
      check_eq("sweep_waddr", buf_waddr, k);
      check_eq("sweep_wdata", buf_wdata, 0);
      check_eq("sweep_done", clear_done, (k == DP - 1) ? 1 : 0);
      cyc();
    end
    check_eq("run_busy", busy, 0);
    check_eq("run_clear_done", clear_done, 0);

    // Requester 2 writes then reads address 5
    set_req(2, 1'b1, 1'b1, 5'd5, PAT_A5);
    #1;
    check_eq("wr_grant", req_ready, 4'b0100);
    check_eq("wr_wen", buf_wen, 1);
    check_eq("wr_ren", buf_ren, 0);
    check_eq("wr_waddr", buf_waddr, 5);
    check_eq("wr_wdata", buf_wdata, PAT_A5);
    cyc();
    set_req(2, 1'b1, 1'b0, 5'd5, '0);
    #1;
    check_eq("rd_grant", req_ready, 4'b0100);
    check_eq("rd_ren", buf_ren, 1);
    check_eq("rd_wen", buf_wen, 0);
    check_eq("rd_raddr", buf_raddr, 5);
    cyc();
    idle();
    #1;
    check_eq("rd_rsp_valid", rsp_valid, 4'b0100);
    check_eq("rd_rsp_data", rsp_data, PAT_A5);
    cyc();
    check_eq("no_rd_rsp_data", rsp_data, 0);

    // Bring the pointer back to 0, then all four read continuously
    set_req(3, 1'b1, 1'b0, 5'd7, '0);
    #1;
    check_eq("rr_pre_grant", req_ready, 4'b1000);
    cyc();
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, (i % 2 == 0) ? 5'd5 : 5'd7, '0);
    #1;
    for (int j = 0; j < 8; j++) begin
      check_eq("rr_grant", req_ready, 4'b0001 << (j % 4));
      check_eq("rr_rsp_valid", rsp_valid, 4'b0001 << ((j + 3) % 4));
      check_eq("rr_rsp_data", rsp_data, ph3_data((j + 3) % 4));
      cyc();
    end
    idle();
    #1;
    check_eq("rr_last_rsp", rsp_valid, 4'b1000);
    cyc();

    // Mixed random traffic against a scoreboard and a round-robin model
    for (int i = 0; i < DP; i++) sb[i] = '0;
    sb[5]    = PAT_A5;
    mptr     = 0;
    pend_vld = '0;
    pend_data = '0;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NR; i++) begin
        for (int w = 0; w < 8; w++) rnd_d[w*32 +: 32] = $urandom;
        set_req(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                AW'($urandom_range(0, 7)), rnd_d);
      end
      #1;
      check_eq("mix_rsp_valid", rsp_valid, pend_vld);
      check_eq("mix_rsp_data", rsp_data, pend_data);
      found = 1'b0;
      g = 0;
      for (int k = 0; k < NR; k++) begin
        idx = (mptr + k) % NR;
        if (!found && req_valid[idx]) begin
          found = 1'b1;
          g = idx;
        end
      end
      exp_rdy = found ? NR'(1 << g) : '0;
      check_eq("mix_grant", req_ready, exp_rdy);
      pend_vld  = '0;
      pend_data = '0;
      if (found) begin
        mptr  = (g + 1) % NR;
        a_tmp = req_addr[g*AW +: AW];
        if (req_write[g]) sb[a_tmp] = req_wdata[g*WD +: WD];
        else begin
          pend_vld  = exp_rdy;
          pend_data = sb[a_tmp];
        end
      end
      cyc();
    end
    idle();
    #1;
    check_eq("mix_tail_valid", rsp_valid, pend_vld);
    check_eq("mix_tail_data", rsp_data, pend_data);
    cyc();

    // clear_req alongside a read: the read completes, then a 32-cycle sweep
    set_req(1, 1'b1, 1'b0, 5'd5, '0);
    clear_req = 1'b1;
    #1;
    check_eq("clr_req_grant", req_ready, 4'b0010);
    check_eq("clr_req_ren", buf_ren, 1);
    cyc();
    clear_req = 1'b0;
    set_req(1, 1'b1, 1'b0, 5'd9, '0);
    #1;
    check_eq("clr_rsp_valid", rsp_valid, 4'b0010);
    check_eq("clr_rsp_data", rsp_data, sb[5]);
    for (int k = 0; k < DP; k++) begin
      check_eq("clr_ready", req_ready, 0);
      check_eq("clr_busy", busy, 1);
      check_eq("clr_waddr", buf_waddr, k);
      check_eq("clr_done", clear_done, (k == DP - 1) ? 1 : 0);
      cyc();
    end
    check_eq("clr_after_grant", req_ready, 4'b0010);
    check_eq("clr_after_raddr", buf_raddr, 9);
    cyc();
    idle();
    #1;
    check_eq("clr_read_valid", rsp_valid, 4'b0010);
    check_eq("clr_read_zero", rsp_data, 0);
    cyc();

    // Reset while a read response is outstanding
    set_req(0, 1'b1, 1'b0, 5'd3, '0);
    #1;
    check_eq("rst_rd_grant", req_ready, 4'b0001);
    cyc();
    idle();
    #1;
    check_eq("rst_rd_pending", rsp_valid, 4'b0001);
    reset = 1'b1;
    #1;
    check_eq("rst_rd_dropped", rsp_valid, 0);
    check_eq("rst_rd_busy", busy, 1);
    check_eq("rst_rd_ren", buf_ren, 0);
    cyc();
    check_eq("rst_rd_stays0", rsp_valid, 0);
    reset = 1'b0;
    #1;
    check_eq("rst_rd_init_wen", buf_wen, 0);
    cyc();

    // Reset ten cycles into a sweep; the next sweep restarts at address 0
    for (int k = 0; k < 10; k++) begin
      check_eq("mid_waddr", buf_waddr, k);
      cyc();
    end
    check_eq("mid_waddr10", buf_waddr, 10);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_wen", buf_wen, 0);
    check_eq("mid_rst_waddr", buf_waddr, 0);
    check_eq("mid_rst_busy", busy, 1);
    check_eq("mid_rst_rsp", rsp_valid, 0);
    cyc();
    reset = 1'b0;
    #1;
    check_eq("mid_init_wen", buf_wen, 0);
    cyc();
    check_eq("mid_restart_wen", buf_wen, 1);
    check_eq("mid_restart_waddr", buf_waddr, 0);
    nwait = 0;
    while (busy && nwait < 40) begin
      cyc();
      nwait++;
    end
    check_eq("resweep_len", nwait, DP);
    check_eq("resweep_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
